seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_pkg.sv | 20 ++
 rtl/seg_hex_decode.sv | 23 ++
 rtl/seg_scan_ctrl.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg -- shared constants and helpers for the multiplexed
// seven-segment scan controller.
//   SEG_OFF      : segment byte for a dark digit (segments off, DP off)
//   HEX_SEG      : 7-bit g..a pattern for each hex nibble 0-F
//   dwell_cycles : clocks spent on one digit for a given clock and dwell
package seg_scan_pkg;

  localparam logic [7:0] SEG_OFF = 8'h80;

  // Element n holds the pattern for nibble n (element 0 is rightmost).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int dwell_cycles(input int clk_hz, input int scan_us);
    return (clk_hz / 1_000_000) * scan_us;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode -- combinational nibble to segment-byte decoder.
// Ports:
//   nibble [3:0] : hex value to show
//   dp           : decimal point, 1 = lit
//   blank        : 1 = digit dark (overrides dp)
//   seg    [7:0] : [6:0] = g..a active-high, [7] = DP active-low
module seg_hex_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg = {~dp, HEX_SEG[nibble]};
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl -- time-multiplexed seven-segment display scanner with a
// frame-synchronous shadow register, so a frame never mixes old and new data.
// Optional build macro: SEG_GHOST_GUARD_EN -- blanks the first GUARD_CYC
// clocks of every dwell to suppress ghosting between digits.
// Ports:
//   CLK_50M    : clock, rising edge
//   RST_N      : asynchronous active-low reset
//   DIGIT_VAL  : one hex nibble per digit, digit i at [4i+3:4i]
//   DP_IN      : decimal point per digit, 1 = lit
//   BLANK_IN   : blank mask per digit, 1 = dark
//   LOAD       : one-cycle strobe capturing the three inputs into the shadow
//   UPD_PEND   : shadow holds data not yet shown
//   FRAME_TICK : one-cycle pulse on the last clock of each frame
//   SEG_EN     : digit enables, active-low, one-hot-low
//   SEG_DATA   : [6:0] = g..a active-high, [7] = DP active-low
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_US   = 1000,
  parameter int GUARD_CYC = 16
) (
  input  logic                  CLK_50M,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   DIGIT_VAL,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic [DIGITS-1:0]     BLANK_IN,
  input  logic                  LOAD,
  output logic                  UPD_PEND,
  output logic                  FRAME_TICK,
  output logic [DIGITS-1:0]     SEG_EN,
  output logic [7:0]            SEG_DATA
);

  localparam int DWELL = dwell_cycles(CLK_HZ, SCAN_US);
  localparam int PW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $error("seg_scan_ctrl: DIGITS must be 1..8");
  end
  if (DWELL < 2) begin : g_bad_dwell
    $error("seg_scan_ctrl: dwell must be at least 2 clocks");
  end
  if (GUARD_CYC < 0) begin : g_bad_guard
    $error("seg_scan_ctrl: GUARD_CYC must be non-negative");
  end

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  dwell_end;
  logic                  frame_end;

  logic [4*DIGITS-1:0]   shd_val, act_val;
  logic [DIGITS-1:0]     shd_dp, act_dp;
  logic [DIGITS-1:0]     shd_blank, act_blank;
  logic                  upd_pend;

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [DIGITS-1:0]     en_nxt;
  logic [7:0]            dec_seg;
  logic                  guard;

  assign dwell_end  = (presc == PRESC_LAST);
  assign frame_end  = dwell_end && (idx == IDX_LAST);
  assign FRAME_TICK = frame_end;
  assign UPD_PEND   = upd_pend;

  // Prescaler and digit index.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      presc <= '0;
      idx   <= '0;
    end else if (dwell_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Shadow/active registers. The active copy reads the shadow before this
  // edge's LOAD overwrites it, so a LOAD on the boundary cycle waits a frame.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      shd_val   <= '0;
      shd_dp    <= '0;
      shd_blank <= '1;
      act_val   <= '0;
      act_dp    <= '0;
      act_blank <= '1;
      upd_pend  <= 1'b0;
    end else begin
      if (frame_end && upd_pend) begin
        act_val   <= shd_val;
        act_dp    <= shd_dp;
        act_blank <= shd_blank;
      end
      if (LOAD) begin
        shd_val   <= DIGIT_VAL;
        shd_dp    <= DP_IN;
        shd_blank <= BLANK_IN;
      end
      upd_pend <= LOAD | (upd_pend & ~frame_end);
    end
  end

  // Select the current digit's active data and build the one-hot-low enable.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    en_nxt    = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = act_val[4*i +: 4];
        cur_dp    = act_dp[i];
        cur_blank = act_blank[i];
        en_nxt[i] = 1'b0;
      end
    end
  end

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .blank  (cur_blank),
    .seg    (dec_seg)
  );

`ifdef SEG_GHOST_GUARD_EN
  if (DWELL <= GUARD_CYC + 1) begin : g_bad_guard_len
    $error("seg_scan_ctrl: dwell must exceed GUARD_CYC+1");
  end
  localparam logic [PW-1:0] GUARD_LIM = PW'(GUARD_CYC);
  assign guard = (presc < GUARD_LIM);
`else
  assign guard = 1'b0;
`endif

  // Registered outputs: one clock behind the index they describe.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      SEG_EN   <= '1;
      SEG_DATA <= SEG_OFF;
    end else if (guard) begin
      SEG_EN   <= '1;
      SEG_DATA <= SEG_OFF;
    end else begin
      SEG_EN   <= en_nxt;
      SEG_DATA <= dec_seg;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl -- self-checking bench for seg_scan_ctrl with DIGITS=4,
// 1 MHz clock parameter and 4 us dwell (4 clocks per digit, 16 per frame).
// Honours SEG_GHOST_GUARD_EN when defined for the build.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int CLK_HZ    = 1_000_000;
  localparam int SCAN_US   = 4;
  localparam int GUARD_CYC = 1;
  localparam int DWELL     = 4;
  localparam int FRAME     = DWELL * DIGITS;
`ifdef SEG_GHOST_GUARD_EN
  localparam int GUARD = GUARD_CYC;
`else
  localparam int GUARD = 0;
`endif

  // Clock / reset
  logic        CLK_50M = 1'b0;
  logic        RST_N   = 1'b0;
  logic [15:0] DIGIT_VAL = '0;
  logic [3:0]  DP_IN     = '0;
  logic [3:0]  BLANK_IN  = '0;
  logic        LOAD      = 1'b0;
  logic        UPD_PEND;
  logic        FRAME_TICK;
  logic [3:0]  SEG_EN;
  logic [7:0]  SEG_DATA;

  always #10 CLK_50M = ~CLK_50M;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .CLK_HZ    (CLK_HZ),
    .SCAN_US   (SCAN_US),
    .GUARD_CYC (GUARD_CYC)
  ) dut (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .DIGIT_VAL  (DIGIT_VAL),
    .DP_IN      (DP_IN),
    .BLANK_IN   (BLANK_IN),
    .LOAD       (LOAD),
    .UPD_PEND   (UPD_PEND),
    .FRAME_TICK (FRAME_TICK),
    .SEG_EN     (SEG_EN),
    .SEG_DATA   (SEG_DATA)
  );

  // Reference model state: cycles since reset release plus a log of LOADs.
  typedef struct {
    int          c;
    logic [15:0] v;
    logic [3:0]  dp;
    logic [3:0]  bl;
  } load_t;

  load_t loads[$];
  int t = 0;
  int n_tests = 0;
  int n_fail  = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Expected outputs just after edge tt. A frame shows the latest LOAD issued
  // before the tick cycle that precedes it; a LOAD stays pending until the
  // first frame start at least two edges after it.
  function automatic void model(input int tt, output logic [3:0] en, output logic [7:0] sd,
                                output logic tk, output logic pd);
    int s, k, d, p, e, last_c;
    bit have;
    logic [15:0] v;
    logic [3:0]  dp, bl, one;
    en = 4'hF; sd = 8'h80; tk = 1'b0; pd = 1'b0;
    if (tt == 0) return;
    s = tt - 1; k = s / FRAME; d = (s / DWELL) % DIGITS; p = s % DWELL;
    v = '0; dp = '0; bl = 4'hF; have = 0; last_c = 0;
    foreach (loads[i]) begin
      if (loads[i].c < FRAME * k - 1) begin
        v = loads[i].v; dp = loads[i].dp; bl = loads[i].bl;
      end
      if (loads[i].c <= tt - 1) begin
        have = 1; last_c = loads[i].c;
      end
    end
    if (p >= GUARD) begin
      one = 4'b0001;
      en  = ~(one << d);
      if (!bl[d]) sd = {~dp[d], hex_tab[v[4*d +: 4]]};
    end
    tk = ((tt % FRAME) == FRAME - 1);
    if (have) begin
      e  = ((last_c + 2 + FRAME - 1) / FRAME) * FRAME;
      pd = (e > tt);
    end
  endfunction

  // Driver: present inputs for the current cycle, then advance one edge.
  task automatic cycle(input bit ld, input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    LOAD = ld;
    if (ld) begin
      DIGIT_VAL = v; DP_IN = dp; BLANK_IN = bl;
      loads.push_back('{c: t, v: v, dp: dp, bl: bl});
    end else begin
      DIGIT_VAL = 16'($urandom); DP_IN = 4'($urandom); BLANK_IN = 4'($urandom);
    end
    @(posedge CLK_50M);
    if (RST_N) t++;
    #1;
    LOAD = 1'b0;
  endtask

  task automatic align(input int phase);
    for (int i = 0; i < FRAME; i++) begin
      if (t % FRAME == phase) break;
      cycle(0, '0, '0, '0);
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (3) cycle(0, '0, '0, '0);
    n_tests++;
    if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {4'hF, 8'h80, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_hold got en=%h data=%h tick=%b pend=%b want en=f data=80 tick=0 pend=0",
               SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND);
    end
    t = 0;
    loads.delete();
    RST_N = 1'b1;
    #2;
    n_tests++;
    if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {4'hF, 8'h80, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release got en=%h data=%h tick=%b pend=%b want en=f data=80 tick=0 pend=0",
               SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND);
    end
  endtask

  task automatic test_idle_scan;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL idle_scan t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  task automatic test_load_basic;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    align(5);
    cycle(1, 16'hA5F0, 4'b0010, 4'b0000);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL load_basic t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  task automatic test_load_on_tick;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    align(3);
    cycle(1, 16'hA5F0, 4'b0000, 4'b0000);
    align(FRAME - 1);
    n_tests++;
    if (FRAME_TICK !== 1'b1) begin
      n_fail++;
      $display("FAIL tick_cycle t=%0d got tick=%b want 1", t, FRAME_TICK);
    end
    cycle(1, 16'h1234, 4'b0101, 4'b0000);
    n_tests++;
    if (UPD_PEND !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_after_tick_load got %b want 1", UPD_PEND);
    end
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL load_on_tick t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    int s0, seen_one;
    align(0);
    s0 = t;
    seen_one = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == 2)      cycle(1, 16'h1111, 4'b0000, 4'b0000);
      else if (i == 9) cycle(1, 16'h2222, 4'b0000, 4'b0000);
      else             cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL back_to_back t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
      if (t > s0 + FRAME && SEG_EN != 4'hF && SEG_DATA[6:0] == 7'h06) seen_one++;
    end
    n_tests++;
    if (seen_one != 0) begin
      n_fail++;
      $display("FAIL overwritten_load_shown got %0d cycles showing 1 want 0", seen_one);
    end
  endtask

  task automatic test_blank_dp;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    int s0;
    align(0);
    s0 = t;
    cycle(1, 16'($urandom), 4'b1000, 4'b1000);
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL blank_dp t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
      if (t > s0 + FRAME && SEG_EN == 4'b0111) begin
        n_tests++;
        if (SEG_DATA !== 8'h80) begin
          n_fail++;
          $display("FAIL blank_digit3 t=%0d got data=%h want 80", t, SEG_DATA);
        end
      end
    end
  endtask

  task automatic test_hex_sweep;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    align(0);
    for (int i = 0; i < 5 * FRAME + 2; i++) begin
      if (i % FRAME == 4 && i / FRAME < 4) cycle(1, vals[i / FRAME], 4'($urandom), 4'b0000);
      else                                 cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL hex_sweep t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 9) == 0)
        cycle(1, 16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0));
      else
        cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL random t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] e_en; logic [7:0] e_sd; logic e_tk, e_pd;
    align(2);
    cycle(1, 16'h9876, 4'b1111, 4'b0000);
    align(6);
    RST_N = 1'b0;
    #1;
    n_tests++;
    if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {4'hF, 8'h80, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_async got en=%h data=%h tick=%b pend=%b want en=f data=80 tick=0 pend=0",
               SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND);
    end
    t = 0;
    loads.delete();
    cycle(0, '0, '0, '0);
    cycle(1, 16'h5555, 4'b0000, 4'b0000);
    loads.delete();
    n_tests++;
    if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {4'hF, 8'h80, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_hold got en=%h data=%h tick=%b pend=%b want en=f data=80 tick=0 pend=0",
               SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND);
    end
    RST_N = 1'b1;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      cycle(0, '0, '0, '0);
      model(t, e_en, e_sd, e_tk, e_pd);
      n_tests++;
      if ({SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND} !== {e_en, e_sd, e_tk, e_pd}) begin
        n_fail++;
        $display("FAIL reset_mid_resume t=%0d got en=%h data=%h tick=%b pend=%b want en=%h data=%h tick=%b pend=%b",
                 t, SEG_EN, SEG_DATA, FRAME_TICK, UPD_PEND, e_en, e_sd, e_tk, e_pd);
      end
    end
  endtask

  initial begin
    test_reset;
    test_idle_scan;
    test_load_basic;
    test_load_on_tick;
    test_back_to_back;
    test_blank_dp;
    test_hex_sweep;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
